// File: rtl/copro_pkg.sv
// Shared types for the FPU coprocessor sequencer: opcodes, FSM states, datapath
// selector and default unit latencies.
package copro_pkg;
  import float_pack::*;

  typedef enum logic [2:0] {
    OP_ADD    = 3'd0,
    OP_SUB    = 3'd1,
    OP_MUL    = 3'd2,
    OP_MAC    = 3'd3,
    OP_CLRACC = 3'd4,
    OP_RDACC  = 3'd5,
    OP_ILL6   = 3'd6,
    OP_ILL7   = 3'd7
  } copro_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_MACADD = 2'd2,
    ST_DONE   = 2'd3
  } copro_state_t;

  typedef enum logic [1:0] {
    DP_ADD = 2'd0,
    DP_SUB = 2'd1,
    DP_MUL = 2'd2
  } dp_op_t;

  localparam int ADD_LAT_DEF = 2;
  localparam int MUL_LAT_DEF = 3;

  function automatic int lat_cnt_w(input int add_lat, input int mul_lat);
    return $clog2(add_lat + mul_lat + 1);
  endfunction

endpackage

// File: rtl/float_pack.sv
// Reduced internal float format (1 sign, 8 exponent, 16 mantissa bits, bias 127) with
// IEEE-single conversions and combinational add/sub/mul helpers. Exponent 0 encodes zero.
package float_pack;

  localparam int NE = 8;
  localparam int NM = 16;
  localparam logic [NE-1:0] E_MAX = 8'hFE;

  typedef struct packed {
    logic          s;
    logic [NE-1:0] e;
    logic [NM-1:0] m;
  } float_t;

  function automatic float_t float_sat(input logic s);
    float_t f;
    f.s = s;
    f.e = E_MAX;
    f.m = '1;
    return f;
  endfunction

  // Mantissa is truncated; denormals flush to zero, Inf/NaN clamp to the largest finite value.
  function automatic float_t float_ieee2float(input logic [31:0] x);
    float_t f;
    f.s = x[31];
    f.e = x[30:23];
    f.m = NM'(x >> 7);
    if (x[30:23] == 8'h00) f = '0;
    else if (x[30:23] == 8'hFF) f = float_sat(x[31]);
    return f;
  endfunction

  function automatic logic [31:0] float2float_ieee(input float_t f);
    if (f.e == '0) return 32'h0000_0000;
    return {f.s, f.e, f.m, 7'h00};
  endfunction

  function automatic float_t float_mul(input float_t a, input float_t b);
    logic [2*NM+1:0] p;
    float_t          r;
    int              ex;
    p   = {{(NM+1){1'b0}}, 1'b1, a.m} * {{(NM+1){1'b0}}, 1'b1, b.m};
    ex  = int'(a.e) + int'(b.e) - 127;
    r.s = a.s ^ b.s;
    if (p[2*NM+1]) begin
      r.m = NM'(p >> (NM + 1));
      ex  = ex + 1;
    end else begin
      r.m = NM'(p >> NM);
    end
    r.e = NE'(ex);
    if (a.e == '0 || b.e == '0 || ex < 1) r = '0;
    else if (ex > int'(E_MAX)) r = float_sat(a.s ^ b.s);
    return r;
  endfunction

  // A zero operand passes the other operand through untouched.
  function automatic float_t float_add(input float_t a, input float_t b);
    float_t        big, sml, r;
    logic [NE-1:0] d;
    logic [NM:0]   ma, mb, diff;
    logic [NM+1:0] sum;
    int            pos, ex;
    r = '0;
    if (a.e == '0) return b;
    if (b.e == '0) return a;
    if ({a.e, a.m} >= {b.e, b.m}) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    d  = big.e - sml.e;
    ma = {1'b1, big.m};
    mb = {1'b1, sml.m} >> d;
    if (big.s == sml.s) begin
      sum = {1'b0, ma} + {1'b0, mb};
      r.s = big.s;
      if (sum[NM+1]) begin
        if (big.e == E_MAX) r = float_sat(big.s);
        else begin
          r.e = big.e + NE'(1);
          r.m = NM'(sum >> 1);
        end
      end else begin
        r.e = big.e;
        r.m = NM'(sum);
      end
    end else begin
      diff = ma - mb;
      pos  = 0;
      for (int i = 0; i <= NM; i++) if (diff[i]) pos = i;
      ex = int'(big.e) - (NM - pos);
      if (diff == '0 || ex < 1) r = '0;
      else begin
        r.s = big.s;
        r.e = NE'(ex);
        r.m = NM'(diff << (NM - pos));
      end
    end
    return r;
  endfunction

  function automatic float_t float_sub(input float_t a, input float_t b);
    float_t nb;
    nb   = b;
    nb.s = ~b.s;
    return float_add(a, nb);
  endfunction

endpackage

// File: rtl/copro_fpu_dp.sv
// Combinational add/sub/mul unit on the internal float format; the sequencer uses
// one copy for issued ops and a second as the MAC accumulate adder.
module copro_fpu_dp
  import float_pack::*;
  import copro_pkg::*;
(
  input  dp_op_t op_i,
  input  float_t a_i,
  input  float_t b_i,
  output float_t y_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      DP_SUB:  y_o = float_sub(a_i, b_i);
      DP_MUL:  y_o = float_mul(a_i, b_i);
      default: y_o = float_add(a_i, b_i);
    endcase
  end

endmodule

// File: rtl/copro_fpu_sequencer.sv
// Single-outstanding command sequencer for the float coprocessor: converts operands,
// times the shared datapath, owns the MAC accumulator and returns IEEE results.
//
// state     | meaning
// ST_IDLE   | ready for a command
// ST_EXEC   | issued op in the datapath, counting unit latency
// ST_MACADD | MAC product being added into the accumulator
// ST_DONE   | result held until the consumer takes it
module copro_fpu_sequencer
  import float_pack::*;
  import copro_pkg::*;
#(
  parameter int ADD_LAT = ADD_LAT_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int OPC_W   = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [OPC_W-1:0] cmd_opcode_i,
  input  logic [31:0]      cmd_a_i,
  input  logic [31:0]      cmd_b_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [31:0]      res_data_o,
  output logic             res_err_o,
  output logic             busy_o
);

  localparam int CNT_W = lat_cnt_w(ADD_LAT, MUL_LAT);
  typedef logic [CNT_W-1:0] cnt_t;

  copro_state_t state_q, state_d;
  copro_op_t    op_q, op_d;
  cnt_t         cnt_q, cnt_d;
  float_t       a_q, a_d, b_q, b_d;
  float_t       res_q, res_d, prod_q, prod_d, sum_q, sum_d, acc_q, acc_d;
  logic         first_q, first_d;
  logic [31:0]  data_q, data_d;
  logic         err_q, err_d;

  dp_op_t issue_op;
  float_t issue_y, add_y, res_now, sum_now;

  always_comb begin
    issue_op = DP_ADD;
    case (op_q)
      OP_SUB:         issue_op = DP_SUB;
      OP_MUL, OP_MAC: issue_op = DP_MUL;
      default:        issue_op = DP_ADD;
    endcase
  end

  copro_fpu_dp u_dp_issue (
    .op_i (issue_op),
    .a_i  (a_q),
    .b_i  (b_q),
    .y_o  (issue_y)
  );

  copro_fpu_dp u_dp_macadd (
    .op_i (DP_ADD),
    .a_i  (acc_q),
    .b_i  (prod_q),
    .y_o  (add_y)
  );

  // On the first cycle of a phase the register has not loaded yet, so take the unit output.
  assign res_now = first_q ? issue_y : res_q;
  assign sum_now = first_q ? add_y : sum_q;

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign res_valid_o = (state_q == ST_DONE);
  assign busy_o      = (state_q != ST_IDLE);
  assign res_data_o  = data_q;
  assign res_err_o   = err_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    prod_d  = prod_q;
    sum_d   = sum_q;
    acc_d   = acc_q;
    first_d = first_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          a_d     = float_ieee2float(cmd_a_i);
          b_d     = float_ieee2float(cmd_b_i);
          first_d = 1'b1;
          err_d   = 1'b0;
          data_d  = 32'h0000_0000;
          if (cmd_opcode_i > OPC_W'(OP_RDACC)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            op_d = copro_op_t'(cmd_opcode_i);
            case (copro_op_t'(cmd_opcode_i))
              OP_ADD, OP_SUB: begin
                cnt_d   = cnt_t'(ADD_LAT - 1);
                state_d = ST_EXEC;
              end
              OP_MUL, OP_MAC: begin
                cnt_d   = cnt_t'(MUL_LAT - 1);
                state_d = ST_EXEC;
              end
              OP_CLRACC: begin
                acc_d   = '0;
                state_d = ST_DONE;
              end
              default: begin
                data_d  = float2float_ieee(acc_q);
                state_d = ST_DONE;
              end
            endcase
          end
        end
      end
      ST_EXEC: begin
        first_d = 1'b0;
        if (first_q) res_d = issue_y;
        if (cnt_q == '0) begin
          if (op_q == OP_MAC) begin
            prod_d  = res_now;
            cnt_d   = cnt_t'(ADD_LAT - 1);
            first_d = 1'b1;
            state_d = ST_MACADD;
          end else begin
            data_d  = float2float_ieee(res_now);
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      ST_MACADD: begin
        first_d = 1'b0;
        if (first_q) sum_d = add_y;
        if (cnt_q == '0) begin
          acc_d   = sum_now;
          data_d  = float2float_ieee(sum_now);
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      default: begin
        if (res_ready_i) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      prod_q  <= '0;
      sum_q   <= '0;
      acc_q   <= '0;
      first_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      prod_q  <= prod_d;
      sum_q   <= sum_d;
      acc_q   <= acc_d;
      first_q <= first_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_copro_fpu_sequencer.sv
// Scoreboard bench for copro_fpu_sequencer: directed commands push expected results,
// a negedge monitor checks data, error flag and accept-to-valid latency.
module tb_copro_fpu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_opcode = 3'd0;
  logic [31:0] cmd_a = 32'h0;
  logic [31:0] cmd_b = 32'h0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_data;
  logic        res_err;
  logic        busy;

  always #5 clk = ~clk;

  copro_fpu_sequencer dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_opcode_i (cmd_opcode),
    .cmd_a_i      (cmd_a),
    .cmd_b_i      (cmd_b),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .res_data_o   (res_data),
    .res_err_o    (res_err),
    .busy_o       (busy)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  bit   prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) accept_cyc = cyc + 1;
      if (res_valid) begin
        if (!prev_valid) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected result: data %h err %b with nothing expected", res_data, res_err);
          end else begin
            cur = sb.pop_front();
            chk({cur.name, " latency"}, 32'(cyc - accept_cyc + 1), 32'(cur.lat));
          end
        end
        chk({cur.name, " data"}, res_data, cur.data);
        chk({cur.name, " err"}, 32'(res_err), 32'(cur.err));
        chk({cur.name, " cmd_ready in DONE"}, 32'(cmd_ready), 32'd0);
      end
      prev_valid = res_valid;
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ed, input logic ee, input int lat,
                       input string name, input bit push);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, " ready before issue"}, 32'(cmd_ready), 32'd1);
    if (push) sb.push_back('{ed, ee, lat, name});
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!cmd_ready && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, " back to idle"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ed, input logic ee, input int lat, input string name);
    issue(op, a, b, ed, ee, lat, name, 1'b1);
    wait_idle(name);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, " res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, " res_data"}, res_data, 32'h0);
    chk({tag, " res_err"}, 32'(res_err), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;

    run(3'd0, 32'h3FC0_0000, 32'h4010_0000, 32'h4070_0000, 1'b0, 3, "add 1.5+2.25");
    run(3'd2, 32'h4040_0000, 32'hC000_0000, 32'hC0C0_0000, 1'b0, 4, "mul 3*-2");
    run(3'd1, 32'h40A0_0000, 32'h40A0_0000, 32'h0000_0000, 1'b0, 3, "sub 5-5");
    run(3'd1, 32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 1'b0, 3, "sub 1-2");
    run(3'd0, 32'h0000_0000, 32'hC120_0000, 32'hC120_0000, 1'b0, 3, "add 0+-10");
    run(3'd0, 32'h7F80_0000, 32'h0000_0000, 32'h7F7F_FF80, 1'b0, 3, "add inf sat");
    run(3'd0, 32'h3F80_0001, 32'h0000_0000, 32'h3F80_0000, 1'b0, 3, "add trunc");

    run(3'd4, 32'h0, 32'h0, 32'h0000_0000, 1'b0, 1, "clracc");
    run(3'd3, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 6, "mac 2*3");
    run(3'd3, 32'h3F80_0000, 32'h4080_0000, 32'h4120_0000, 1'b0, 6, "mac 1*4");
    run(3'd5, 32'h0, 32'h0, 32'h4120_0000, 1'b0, 1, "rdacc 10");

    run(3'd7, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 1'b1, 1, "illegal 7");
    run(3'd6, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 1'b1, 1, "illegal 6");
    run(3'd0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 3, "add after illegal");

    res_ready = 1'b0;
    issue(3'd2, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 1'b0, 4, "mul held", 1'b1);
    for (int n = 0; n < 20 && !res_valid; n++) begin
      @(posedge clk);
      #1;
    end
    chk("held result valid", 32'(res_valid), 32'd1);
    cmd_valid  = 1'b1;
    cmd_opcode = 3'd0;
    cmd_a      = 32'h3F80_0000;
    cmd_b      = 32'h3F80_0000;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      #1;
      chk("hold valid", 32'(res_valid), 32'd1);
      chk("hold busy", 32'(busy), 32'd1);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    wait_idle("mul held");

    issue(3'd3, 32'h3F80_0000, 32'h3F80_0000, 32'h0, 1'b0, 0, "mac aborted", 1'b0);
    chk("mac aborted busy in exec", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_vals("mid-op reset");
    rst = 1'b0;
    run(3'd5, 32'h0, 32'h0, 32'h0000_0000, 1'b0, 1, "rdacc after reset");

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
